// File: rtl/chip8_mem_seq.sv
// rtl/chip8_mem_seq.sv - CHIP-8 Fx55/Fx65/Fx33 memory sequencer; CHIP8_I_INCREMENT_EN enables I post-increment
module chip8_mem_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [3:0]  x,
  input  logic [11:0] i_addr,
  output logic [3:0]  rf_raddr,
  input  logic [7:0]  rf_rdata,
  output logic        rf_we,
  output logic [3:0]  rf_waddr,
  output logic [7:0]  rf_wdata,
  output logic [11:0] mem_addr,
  output logic        mem_re,
  output logic        mem_we,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic        i_we,
  output logic [11:0] i_wdata,
  output logic        stall,
  output logic        done,
  output logic        trap
);

  typedef enum logic [2:0] {IDLE, STORE, LOAD, LOAD_TAIL, BCD, FIN} state_t;

  state_t      state, state_next;
  logic [3:0]  k, k_next, x_q;
  logic [11:0] i_q, addr_k;
  logic [7:0]  v_q, rem;
  logic        trap_q;
  logic [1:0]  hund;
  logic [3:0]  tens, ones;
  logic [7:0]  digit;
`ifdef CHIP8_I_INCREMENT_EN
  logic        bcd_q;
`endif

  assign addr_k = i_q + {8'd0, k};
  assign trap   = trap_q;

  // Subtract-compare BCD split of the latched Vx
  always_comb begin
    hund = 2'd0;
    rem  = v_q;
    if (v_q >= 8'd200) begin
      hund = 2'd2;
      rem  = v_q - 8'd200;
    end else if (v_q >= 8'd100) begin
      hund = 2'd1;
      rem  = v_q - 8'd100;
    end
    tens = 4'd0;
    for (int d = 1; d < 10; d++) begin
      if (rem >= 8'(d * 10)) tens = 4'(d);
    end
    ones = 4'(rem - 8'(tens) * 8'd10);
    case (k)
      4'd0:    digit = {6'd0, hund};
      4'd1:    digit = {4'd0, tens};
      default: digit = {4'd0, ones};
    endcase
  end

  always_comb begin
    state_next = state;
    k_next     = k;
    rf_raddr   = 4'd0;
    rf_we      = 1'b0;
    rf_waddr   = 4'd0;
    rf_wdata   = 8'd0;
    mem_addr   = 12'd0;
    mem_re     = 1'b0;
    mem_we     = 1'b0;
    mem_wdata  = 8'd0;
    i_we       = 1'b0;
    i_wdata    = 12'd0;
    stall      = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        // rst gates the pass-through paths so outputs read zero during reset
        if (rst) rf_raddr = x;
        stall = start && rst;
        if (start) begin
          k_next = 4'd0;
          case (op)
            2'd0:    state_next = STORE;
            2'd1:    state_next = LOAD;
            2'd2:    state_next = BCD;
            default: state_next = IDLE;
          endcase
        end
      end
      STORE: begin
        stall     = 1'b1;
        rf_raddr  = k;
        mem_we    = 1'b1;
        mem_addr  = addr_k;
        mem_wdata = rf_rdata;
        if (k == x_q) state_next = FIN;
        else          k_next     = k + 4'd1;
      end
      LOAD: begin
        stall    = 1'b1;
        mem_re   = 1'b1;
        mem_addr = addr_k;
        if (k != 4'd0) begin
          rf_we    = 1'b1;
          rf_waddr = k - 4'd1;
          rf_wdata = mem_rdata;
        end
        if (k == x_q) state_next = LOAD_TAIL;
        else          k_next     = k + 4'd1;
      end
      LOAD_TAIL: begin
        stall      = 1'b1;
        rf_we      = 1'b1;
        rf_waddr   = x_q;
        rf_wdata   = mem_rdata;
        state_next = FIN;
      end
      BCD: begin
        stall     = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = addr_k;
        mem_wdata = digit;
        if (k == 4'd2) state_next = FIN;
        else           k_next     = k + 4'd1;
      end
      FIN: begin
        done = 1'b1;
`ifdef CHIP8_I_INCREMENT_EN
        if (!bcd_q) begin
          i_we    = 1'b1;
          i_wdata = i_q + {8'd0, x_q} + 12'd1;
        end
`endif
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      k      <= 4'd0;
      x_q    <= 4'd0;
      i_q    <= 12'd0;
      v_q    <= 8'd0;
      trap_q <= 1'b0;
`ifdef CHIP8_I_INCREMENT_EN
      bcd_q  <= 1'b0;
`endif
    end else begin
      state  <= state_next;
      k      <= k_next;
      trap_q <= (state == IDLE) && start && (op == 2'd3);
      if (state == IDLE && start) begin
        x_q <= x;
        i_q <= i_addr;
        v_q <= rf_rdata;
`ifdef CHIP8_I_INCREMENT_EN
        bcd_q <= (op == 2'd2);
`endif
      end
    end
  end

endmodule

// File: tb/tb_chip8_mem_seq.sv
// tb/tb_chip8_mem_seq.sv - scoreboard bench for chip8_mem_seq (honours CHIP8_I_INCREMENT_EN)
module tb_chip8_mem_seq;
  logic        clk = 1'b0, rst = 1'b0, start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [3:0]  x = 4'd0;
  logic [11:0] i_addr = 12'd0;
  logic [3:0]  rf_raddr, rf_waddr;
  logic [7:0]  rf_rdata, rf_wdata, mem_wdata, mem_rdata;
  logic [11:0] mem_addr, i_wdata;
  logic        rf_we, mem_re, mem_we, i_we, stall, done, trap;

  chip8_mem_seq dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .x(x), .i_addr(i_addr),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .i_we(i_we), .i_wdata(i_wdata),
    .stall(stall), .done(done), .trap(trap)
  );

  always #5 clk = ~clk;

  localparam int K_MW = 0, K_MR = 1, K_RW = 2, K_DONE = 3, K_TRAP = 4, K_IWE = 5;

  logic [7:0] ram [4096];
  logic [7:0] rf [16];
  int m_ram [4096];
  int m_rf [16];

  assign rf_rdata = rf[rf_raddr];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= ram[mem_addr];
    if (rf_we)  rf[rf_waddr] <= rf_wdata;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int kind; int cyc; int addr; int data;} ev_t;
  ev_t q[$];
  int checks = 0, errors = 0;

  function automatic void expect_ev(int kind, int c, int a, int d);
    ev_t e;
    e.kind = kind; e.cyc = c; e.addr = a; e.data = d;
    q.push_back(e);
  endfunction

  function automatic void got(int kind, int a, int d);
    ev_t e;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event kind=%0d cyc=%0d addr=%h data=%h required none", kind, cyc, a, d);
    end else begin
      e = q.pop_front();
      if (e.kind != kind || e.cyc != cyc || e.addr != a || e.data != d) begin
        errors++;
        $display("FAIL event got kind=%0d cyc=%0d addr=%h data=%h required kind=%0d cyc=%0d addr=%h data=%h",
                 kind, cyc, a, d, e.kind, e.cyc, e.addr, e.data);
      end
    end
  endfunction

  // Monitor: every strobe the DUT raises must match the next expected event
  always @(negedge clk) begin
    if (rst) begin
      if (mem_we) got(K_MW, int'(mem_addr), int'(mem_wdata));
      if (mem_re) got(K_MR, int'(mem_addr), 0);
      if (rf_we)  got(K_RW, int'(rf_waddr), int'(rf_wdata));
      if (done)   got(K_DONE, 0, 0);
      if (trap)   got(K_TRAP, 0, 0);
      if (i_we)   got(K_IWE, 0, int'(i_wdata));
    end
  end

  task automatic set_rf(input int idx, input int v);
    rf[idx] = 8'(v);
    m_rf[idx] = v;
  endtask

  task automatic set_ram(input int a, input int v);
    ram[a] = 8'(v);
    m_ram[a] = v;
  endtask

  task automatic check_quiet(input string name);
    checks++;
    if ({rf_we, mem_re, mem_we, done, trap, i_we, stall} !== 7'd0 ||
        {rf_raddr, mem_addr, mem_wdata, rf_waddr, rf_wdata, i_wdata} !== 56'd0) begin
      errors++;
      $display("FAIL %s strobes=%b addrdata=%h required all zero", name,
               {rf_we, mem_re, mem_we, done, trap, i_we, stall},
               {rf_raddr, mem_addr, mem_wdata, rf_waddr, rf_wdata, i_wdata});
    end
  endtask

  task automatic run_op(input int o, input int xx, input int ii, input bit hold);
    int c0, len, v;
    int dig [3];
    @(posedge clk); #1;
    c0 = cyc;
    case (o)
      0: begin
        for (int k = 0; k <= xx; k++) begin
          expect_ev(K_MW, c0 + 1 + k, (ii + k) % 4096, m_rf[k]);
          m_ram[(ii + k) % 4096] = m_rf[k];
        end
        len = xx + 2;
      end
      1: begin
        for (int c = 1; c <= xx + 2; c++) begin
          if (c <= xx + 1) expect_ev(K_MR, c0 + c, (ii + c - 1) % 4096, 0);
          if (c >= 2)      expect_ev(K_RW, c0 + c, c - 2, m_ram[(ii + c - 2) % 4096]);
        end
        for (int k = 0; k <= xx; k++) m_rf[k] = m_ram[(ii + k) % 4096];
        len = xx + 3;
      end
      2: begin
        v = m_rf[xx];
        dig[0] = v / 100; dig[1] = (v / 10) % 10; dig[2] = v % 10;
        for (int k = 0; k < 3; k++) begin
          expect_ev(K_MW, c0 + 1 + k, (ii + k) % 4096, dig[k]);
          m_ram[(ii + k) % 4096] = dig[k];
        end
        len = 4;
      end
      default: begin
        expect_ev(K_TRAP, c0 + 1, 0, 0);
        len = 1;
      end
    endcase
    if (o < 3) expect_ev(K_DONE, c0 + len, 0, 0);
`ifdef CHIP8_I_INCREMENT_EN
    if (o < 2) expect_ev(K_IWE, c0 + len, 0, (ii + xx + 1) % 4096);
`endif
    start = 1'b1; op = 2'(o); x = 4'(xx); i_addr = 12'(ii);
    #1;
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("FAIL stall_on_start op=%0d got %b required 1", o, stall);
    end
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    else begin
      op = 2'($urandom); x = 4'($urandom); i_addr = 12'($urandom);
    end
    if (len > 1) begin
      repeat (len - 1) @(posedge clk);
      #1;
    end
    start = 1'b0;
  endtask

  initial begin
    int o, xx, ii, bad;
    for (int a = 0; a < 4096; a++) set_ram(a, int'($urandom_range(0, 255)));
    for (int r = 0; r < 16; r++) set_rf(r, int'($urandom_range(0, 255)));
    x = 4'hA;
    #2 check_quiet("reset_state");
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;

    set_rf(0, 'h11); set_rf(1, 'h22); set_rf(2, 'h33);
    run_op(0, 2, 'h300, 1'b0);
    set_ram('hFFF, 'hAB); set_ram('h000, 'hCD);
    run_op(1, 1, 'hFFF, 1'b0);
    set_rf(5, 'hFE); run_op(2, 5, 'h200, 1'b0);
    set_rf(5, 'h00); run_op(2, 5, 'h200, 1'b0);
    set_rf(5, 'h09); run_op(2, 5, 'h200, 1'b0);
    run_op(3, 6, 'h456, 1'b0);
    run_op(0, 7, 'h123, 1'b1);

    // Reset during cycle 3 of a 16-register STORE: only cycles 1 and 2 write
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) begin
      expect_ev(K_MW, cyc + 1 + k, ('h500 + k) % 4096, m_rf[k]);
      m_ram['h500 + k] = m_rf[k];
    end
    start = 1'b1; op = 2'd0; x = 4'd15; i_addr = 12'h500;
    @(posedge clk); #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1 check_quiet("reset_mid_store");
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL reset_pending got %0d events outstanding required 0", q.size());
      q.delete();
    end
    set_rf(3, 'h7B);
    run_op(2, 3, 'hFFE, 1'b0);

    for (int n = 0; n < 40; n++) begin
      o  = int'($urandom_range(0, 3));
      xx = int'($urandom_range(0, 15));
      ii = (n % 4 == 0) ? int'($urandom_range(4080, 4095)) : int'($urandom_range(0, 4095));
      run_op(o, xx, ii, (o != 3) && ($urandom_range(0, 3) == 0));
    end

    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL missing_events got %0d outstanding required 0", q.size());
    end
    bad = 0;
    for (int a = 0; a < 4096; a++) if (int'(ram[a]) != m_ram[a]) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL ram_contents got %0d differing bytes required 0", bad);
    end
    bad = 0;
    for (int r = 0; r < 16; r++) if (int'(rf[r]) != m_rf[r]) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL rf_contents got %0d differing registers required 0", bad);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
